// File: rtl/ps2_scan_receiver_pkg.sv
// Shared constants for the PS/2 scan-code receiver: FSM encoding, frame geometry, code bytes.
// Combinational helper only; no latency, no backpressure.
package ps2_scan_receiver_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DATA   = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_STOP   = 2'd3;

  localparam int FRAME_DATA_BITS = 8;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam int TIMEOUT_CYCLES_DEF = 20000;
  localparam int FILTER_LEN_DEF     = 8;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                    input logic par, input logic stop);
    return stop & (^{data, par});
  endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Keyboard-line and scan-code signals between a PS/2 receiver and its environment.
// Wiring only; no latency, no backpressure.
interface ps2_scan_receiver_if;
  import ps2_scan_receiver_pkg::*;

  logic        PS2_CLK;
  logic        PS2_DATA;
  logic [15:0] KBBuffer;
  logic        NewCode;
  logic        FrameError;
  logic        Busy;

  modport slave (input PS2_CLK, PS2_DATA, output KBBuffer, NewCode, FrameError, Busy);
  modport master(output PS2_CLK, PS2_DATA, input KBBuffer, NewCode, FrameError, Busy);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes and deglitches one PS/2 clock line and strobes on accepted 1->0 transitions.
// Strobe lags the line by 2 sync cycles + FILTER_LEN samples; no backpressure.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic line_in,
  output logic fall_stb
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q   <= 2'b11;
      level_q  <= 1'b1;
      cnt_q    <= '0;
      fall_stb <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], line_in};
      fall_stb <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q  <= sync_q[1];
        cnt_q    <= '0;
        fall_stb <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// Receives PS/2 keyboard frames and shifts each good byte into a 2-byte history buffer.
// NewCode/FrameError one cycle after the stop-bit edge; no backpressure, every byte is presented.
module ps2_scan_receiver
  import ps2_scan_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input logic CLK,
  input logic RESET,
  ps2_scan_receiver_if.slave kb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  logic                       fall_stb;
  logic [1:0]                 data_sync_q;
  logic                       data_s;
  state_t                     state_q;
  logic [2:0]                 bit_cnt_q;
  logic [FRAME_DATA_BITS-1:0] shreg_q;
  logic                       par_q;
  logic [TW-1:0]              to_cnt_q;
  logic [15:0]                kbbuf_q;
  logic                       new_code_q;
  logic                       frame_err_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .CLK      (CLK),
    .RESET    (RESET),
    .line_in  (kb.PS2_CLK),
    .fall_stb (fall_stb)
  );

  assign data_s = data_sync_q[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_sync_q <= 2'b11;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      kbbuf_q     <= '0;
      new_code_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_sync_q <= {data_sync_q[0], kb.PS2_DATA};
      new_code_q  <= 1'b0;
      frame_err_q <= 1'b0;
      // An edge beats a coincident timeout: it clears the counter and advances.
      if (fall_stb) begin
        to_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!data_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg_q <= {data_s, shreg_q[FRAME_DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          ST_PARITY: begin
            par_q   <= data_s;
            state_q <= ST_STOP;
          end
          default: begin
            state_q <= ST_IDLE;
            if (frame_ok(shreg_q, par_q, data_s)) begin
              kbbuf_q    <= {kbbuf_q[7:0], shreg_q};
              new_code_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        endcase
      end else if (state_q != ST_IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          state_q     <= ST_IDLE;
          to_cnt_q    <= '0;
          frame_err_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign kb.KBBuffer   = kbbuf_q;
  assign kb.NewCode    = new_code_q;
  assign kb.FrameError = frame_err_q;
  assign kb.Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: directed scenarios plus random frames vs. a byte-level model.
module tb_ps2_scan_receiver;
  import ps2_scan_receiver_pkg::*;

  localparam int TO_CYC = 300;
  localparam int FL     = 8;

  logic CLK;
  logic RESET;
  ps2_scan_receiver_if kb();

  ps2_scan_receiver #(.TIMEOUT_CYCLES(TO_CYC), .FILTER_LEN(FL)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .kb    (kb.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_err;
    logic [15:0] kbv;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] model_kb;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every output pulse must match the oldest expectation and last one cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET && (kb.NewCode || kb.FrameError)) begin
        chk("exclusive_pulses", 32'(kb.NewCode & kb.FrameError), 32'd0);
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, kb.NewCode, kb.FrameError}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("pulse_kind", {30'd0, kb.NewCode, kb.FrameError}, e.is_err ? 32'd1 : 32'd2);
          chk("kbbuffer", 32'(kb.KBBuffer), 32'(e.kbv));
        end
        @(negedge CLK);
        chk("pulse_width", {30'd0, kb.NewCode, kb.FrameError}, 32'd0);
      end
    end
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    kb.PS2_DATA = b;
    wait_cyc(10);
    kb.PS2_CLK = 1'b0;
    wait_cyc(20);
    kb.PS2_CLK = 1'b1;
    wait_cyc(10);
  endtask

  task automatic push_exp(input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.kbv    = model_kb;
    expq.push_back(e);
  endtask

  // Model works at frame level: a byte is good iff stop=1 and total ones (data+parity) is odd.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop);
    logic par;
    bit   good;
    par  = (($countones(b) % 2) == 0) ^ flip_par;
    good = stop && ((($countones(b) + int'(par)) % 2) == 1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    if (good) model_kb = {model_kb[7:0], b};
    push_exp(!good);
    send_bit(stop);
    kb.PS2_DATA = 1'b1;
    wait_cyc(5);
    chk("drain", expq.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         busy_seen;
    model_kb    = 16'h0000;
    kb.PS2_CLK  = 1'b1;
    kb.PS2_DATA = 1'b1;
    RESET       = 1'b0;
    wait_cyc(5);
    chk("reset_kbbuffer", 32'(kb.KBBuffer), 32'd0);
    chk("reset_pulses_busy", {29'd0, kb.NewCode, kb.FrameError, kb.Busy}, 32'd0);
    RESET = 1'b1;
    wait_cyc(10);

    send_frame(8'h05, 1'b0, 1'b1);
    chk("after_05", 32'(kb.KBBuffer), 32'h0005);
    send_frame(BREAK_CODE, 1'b0, 1'b1);
    send_frame(8'h05, 1'b0, 1'b1);
    chk("break_seq", 32'(kb.KBBuffer), 32'hF005);

    send_frame(8'h1C, 1'b1, 1'b1);
    chk("bad_parity_unchanged", 32'(kb.KBBuffer), 32'hF005);
    send_frame(8'h16, 1'b0, 1'b1);
    chk("after_16", 32'(kb.KBBuffer[7:0]), 32'h16);

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("repeat_1c", 32'(kb.KBBuffer), 32'h1C1C);
    send_frame(EXT_CODE, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0);

    // Clock stalls after four data bits.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("busy_mid_frame", 32'(kb.Busy), 32'd1);
    push_exp(1'b1);
    wait_cyc(TO_CYC + 100);
    chk("timeout_drain", expq.size(), 32'd0);
    chk("timeout_busy", 32'(kb.Busy), 32'd0);
    send_frame(8'h45, 1'b0, 1'b1);
    chk("after_timeout_45", 32'(kb.KBBuffer[7:0]), 32'h45);

    // Short glitch must not register as an edge.
    busy_seen  = 1'b0;
    kb.PS2_CLK = 1'b0;
    wait_cyc(3);
    kb.PS2_CLK = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (kb.Busy) busy_seen = 1'b1;
    end
    chk("glitch_busy", 32'(busy_seen), 32'd0);

    // Reset during bit 6 of a frame.
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    chk("busy_before_reset", 32'(kb.Busy), 32'd1);
    RESET = 1'b0;
    #1;
    chk("midreset_kbbuffer", 32'(kb.KBBuffer), 32'd0);
    chk("midreset_outputs", {29'd0, kb.NewCode, kb.FrameError, kb.Busy}, 32'd0);
    model_kb = 16'h0000;
    wait_cyc(4);
    RESET = 1'b1;
    wait_cyc(50);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("after_reset_5a", 32'(kb.KBBuffer), 32'h005A);

    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0));
      chk("random_kbbuffer", 32'(kb.KBBuffer), 32'(model_kb));
    end

    wait_cyc(20);
    chk("final_queue_empty", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, which is the maximum number of CLK cycles allowed between PS/2 clock falling edges inside a frame.
REQ-002 The block SHALL have parameter FILTER_LEN, default 8, which is the number of consecutive equal samples required before a synchronized PS2_CLK level is accepted.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port PS2_CLK, input, 1 bit: keyboard clock line, asynchronous to CLK.
REQ-006 The block SHALL have port PS2_DATA, input, 1 bit: keyboard data line, asynchronous to CLK.
REQ-007 The block SHALL have port KBBuffer, output, 16 bits: {previous byte, latest byte}; it feeds the keyboard-control block's KBBuffer input directly.
REQ-008 The block SHALL have port NewCode, output, 1 bit: one-cycle pulse when KBBuffer updates.
REQ-009 The block SHALL have port FrameError, output, 1 bit: one-cycle pulse on a discarded frame.
REQ-010 The block SHALL have port Busy, output, 1 bit: high while a frame is in progress (state not IDLE).

Function
REQ-011 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer.
REQ-012 The synchronized PS2_CLK SHALL be filtered: the accepted level changes only after FILTER_LEN identical consecutive samples.
REQ-013 A falling edge SHALL be defined as the filtered clock going 1->0, detected as a one-cycle strobe; PS2_DATA SHALL be sampled (synchronized value) in that strobe cycle.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE: on an edge with data=0 -> DATA, bit counter cleared; on an edge with data=1 -> stay IDLE and pulse FrameError.
- DATA: shift data in LSB first; after the 8th edge -> PARITY; the 3-bit counter is used, with no wrap beyond 8.
- PARITY: store the bit -> STOP.
- STOP: -> IDLE always.
REQ-015 A frame SHALL be valid only when the stop bit = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
REQ-016 On a valid frame, KBBuffer SHALL be loaded with {KBBuffer[7:0], byte}, and NewCode SHALL be 1, both in the cycle after the stop-bit edge strobe (latency 1).
REQ-017 On an invalid frame, KBBuffer SHALL remain unchanged and FrameError SHALL pulse with the same latency.
REQ-018 Every received byte, including E0 and F0 prefixes, SHALL be shifted in, so a break sequence yields KBBuffer[15:8]=F0.
REQ-019 In any non-IDLE state, the timeout counter SHALL clear on each edge and increment otherwise; on reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE, discard the partial byte, and pulse FrameError once.
REQ-020 If an edge and the timeout occur in the same cycle, the edge SHALL win: the counter clears and the FSM advances.
REQ-021 The counter SHALL stay 0 in IDLE and SHALL saturate, never wrapping.
REQ-022 NewCode and FrameError SHALL never be high in the same cycle.
REQ-023 Identical consecutive bytes SHALL still produce NewCode and a buffer shift (e.g. 1C,1C gives 1C1C).

Reset
REQ-024 RESET=0 SHALL immediately force state IDLE, KBBuffer=16'h0000, NewCode=0, FrameError=0, Busy=0, and clear the counters, shift register and filters (filtered clock level = 1).
REQ-025 A reset asserted mid-frame SHALL discard the partial frame, and no pulse SHALL be emitted after release.
REQ-026 The first edge after reset release SHALL be treated as a possible start bit.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, FRAME_DATA_BITS=8, BREAK_CODE=8'hF0, EXT_CODE=8'hE0, and the default TIMEOUT_CYCLES/FILTER_LEN values.
REQ-028 Synchronizer, glitch filter and falling-edge detect SHALL live in one sub-module, ps2_line_filter, instantiated for PS2_CLK; PS2_DATA uses the synchronizer only.

Verification
REQ-029 The bench SHALL cover: frame for 8'h05 with odd parity 1 and stop 1 -> one cycle after the stop edge, KBBuffer=16'h0005 and a single NewCode pulse.
REQ-030 The bench SHALL cover: frames F0 then 05 -> KBBuffer=16'hF005 after the second frame, two NewCode pulses in total.
REQ-031 The bench SHALL cover: frame 8'h1C with the parity bit inverted -> FrameError pulse, KBBuffer unchanged, and the next good frame 8'h16 gives KBBuffer[7:0]=8'h16.
REQ-032 The bench SHALL cover: PS2_CLK stopped after 4 data bits for more than TIMEOUT_CYCLES -> FrameError once, Busy=0, and the following frame 8'h45 is received correctly.
REQ-033 The bench SHALL cover: a 3-cycle low glitch on PS2_CLK while idle -> no edge, Busy stays 0, no pulses.
REQ-034 The bench SHALL cover: RESET=0 asserted at bit 6 of a frame -> all outputs 0 immediately, and the next full frame 8'h5A gives KBBuffer=16'h005A.
